// File: rtl/semi_auto_drive_ctrl.sv
// rtl/semi_auto_drive_ctrl.sv - semi-automatic drive controller: operator commands, timed turns, corridor following
//
// Purpose:
//   Accepts a one-hot operator command while idle (WAIT). It holds a timed
//   turn, or a U-turn when built with SEMI_AUTO_DRIVE_UTURN_EN. It then drives
//   forward for a settle period with the detectors ignored. After that it keeps
//   moving forward while the detectors report a corridor (front clear, walls on
//   both sides) and returns to WAIT on anything else.
//
// Ports:
//   clk                  in   system clock, rising edge
//   rst_n                in   asynchronous active-low reset
//   front/left/right_detector in  high = obstacle present
//   go_straight_command  in   level command -> SETTLE
//   turn_left_command    in   level command -> TURN_L
//   turn_right_command   in   level command -> TURN_R
//   turn_back_command    in   level command -> UTURN (only with SEMI_AUTO_DRIVE_UTURN_EN)
//   move_forward_signal  out  forward drive (SETTLE, MOVE)
//   turn_left_signal     out  left drive (TURN_L, UTURN)
//   turn_right_signal    out  right drive (TURN_R)
//   state                out  WAIT=0 TURN_L=1 TURN_R=2 MOVE=3 SETTLE=4 UTURN=5
//   cmd_error            out  one-cycle pulse when several commands are high in WAIT
//
// Configuration macro: SEMI_AUTO_DRIVE_UTURN_EN (adds turn_back_command and UTURN)

module semi_auto_drive_ctrl #(
    parameter int unsigned TURN_CYCLES   = 1000000,
    parameter int unsigned SETTLE_CYCLES = 500000,
    parameter int unsigned UTURN_CYCLES  = 2000000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       front_detector,
    input  logic       left_detector,
    input  logic       right_detector,
    input  logic       go_straight_command,
    input  logic       turn_left_command,
    input  logic       turn_right_command,
`ifdef SEMI_AUTO_DRIVE_UTURN_EN
    input  logic       turn_back_command,
`endif
    output logic       move_forward_signal,
    output logic       turn_left_signal,
    output logic       turn_right_signal,
    output logic [2:0] state,
    output logic       cmd_error
);

`ifdef SEMI_AUTO_DRIVE_UTURN_EN
    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_TURN_L = 3'd1,
        S_TURN_R = 3'd2,
        S_MOVE   = 3'd3,
        S_SETTLE = 3'd4,
        S_UTURN  = 3'd5
    } state_t;

    localparam int unsigned CMD_W = 4;
    localparam logic [CNT_W-1:0] UTURN_LAST = CNT_W'(UTURN_CYCLES - 1);
`else
    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_TURN_L = 3'd1,
        S_TURN_R = 3'd2,
        S_MOVE   = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    localparam int unsigned CMD_W = 3;
`endif

    // Last counter value of each timed state; the state is left on the edge
    // where the counter holds this value, giving exactly N cycles in the state.
    localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(TURN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_timed;
    logic               r_cmd_error;
    logic               r_err_armed;

    logic [CMD_W-1:0]   w_cmd;
    logic [CMD_W-1:0]   w_cmd_dec;
    logic               w_cmd_one;
    logic               w_cmd_multi;
    logic               w_in_wait;
    logic [2:0]         w_det;

`ifdef SEMI_AUTO_DRIVE_UTURN_EN
    assign w_cmd = {turn_back_command, turn_right_command, turn_left_command, go_straight_command};
`else
    assign w_cmd = {turn_right_command, turn_left_command, go_straight_command};
`endif

    // x & (x-1) clears the lowest set bit: non-zero means two or more commands.
    assign w_cmd_dec   = w_cmd - CMD_W'(1);
    assign w_cmd_multi = (w_cmd & w_cmd_dec) != '0;
    assign w_cmd_one   = (w_cmd != '0) && !w_cmd_multi;
    assign w_in_wait   = (r_state == S_WAIT);
    assign w_det       = {front_detector, left_detector, right_detector};

    always_comb begin
        w_state_next = S_WAIT;
        w_timed      = 1'b0;
        case (r_state)
            S_WAIT: begin
                w_state_next = S_WAIT;
                if (w_cmd_one) begin
                    if (go_straight_command)     w_state_next = S_SETTLE;
                    else if (turn_left_command)  w_state_next = S_TURN_L;
                    else if (turn_right_command) w_state_next = S_TURN_R;
`ifdef SEMI_AUTO_DRIVE_UTURN_EN
                    else                         w_state_next = S_UTURN;
`endif
                end
            end
            S_TURN_L, S_TURN_R: begin
                w_timed      = 1'b1;
                w_state_next = (r_cnt == TURN_LAST) ? S_SETTLE : r_state;
            end
`ifdef SEMI_AUTO_DRIVE_UTURN_EN
            S_UTURN: begin
                w_timed      = 1'b1;
                w_state_next = (r_cnt == UTURN_LAST) ? S_SETTLE : S_UTURN;
            end
`endif
            S_SETTLE: begin
                w_timed      = 1'b1;
                w_state_next = (r_cnt == SETTLE_LAST) ? S_MOVE : S_SETTLE;
            end
            S_MOVE: begin
                // Only a corridor (front clear, both walls) keeps us moving.
                w_state_next = (w_det == 3'b011) ? S_MOVE : S_WAIT;
            end
            default: w_state_next = S_WAIT;
        endcase
    end

    // Counter clears on every state change and idles at zero in untimed states;
    // timed states exit at their last value so it never wraps.
    always_comb begin
        w_cnt_next = '0;
        if (w_timed && (w_state_next == r_state)) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // One error pulse per conflicting episode: re-armed only once the
    // command vector has gone fully idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_error <= 1'b0;
            r_err_armed <= 1'b1;
        end else begin
            r_cmd_error <= w_in_wait && w_cmd_multi && r_err_armed;
            if (w_cmd == '0) begin
                r_err_armed <= 1'b1;
            end else if (w_in_wait && w_cmd_multi && r_err_armed) begin
                r_err_armed <= 1'b0;
            end
        end
    end

    always_comb begin
        move_forward_signal = 1'b0;
        turn_left_signal    = 1'b0;
        turn_right_signal   = 1'b0;
        case (r_state)
            S_TURN_L:         turn_left_signal    = 1'b1;
            S_TURN_R:         turn_right_signal   = 1'b1;
            S_SETTLE, S_MOVE: move_forward_signal = 1'b1;
`ifdef SEMI_AUTO_DRIVE_UTURN_EN
            S_UTURN:          turn_left_signal    = 1'b1;
`endif
            default: ;
        endcase
    end

    assign state     = r_state;
    assign cmd_error = r_cmd_error;

endmodule

// File: tb/tb_semi_auto_drive_ctrl.sv
// tb/tb_semi_auto_drive_ctrl.sv - scoreboard bench for semi_auto_drive_ctrl

module tb_semi_auto_drive_ctrl;

    localparam int unsigned TURN_CYCLES   = 4;
    localparam int unsigned SETTLE_CYCLES = 3;
    localparam int unsigned UTURN_CYCLES  = 8;

    // Command encoding used by the bench: {back, right, left, straight}
    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_S    = 4'b0001;
    localparam logic [3:0] C_L    = 4'b0010;
    localparam logic [3:0] C_R    = 4'b0100;
    localparam logic [3:0] C_B    = 4'b1000;

    // Motion encoding: {forward, left, right}
    localparam logic [2:0] M_NONE = 3'b000;
    localparam logic [2:0] M_FWD  = 3'b100;
    localparam logic [2:0] M_LEFT = 3'b010;
    localparam logic [2:0] M_RGT  = 3'b001;

    localparam logic [2:0] ST_WAIT   = 3'd0;
    localparam logic [2:0] ST_TURN_L = 3'd1;
    localparam logic [2:0] ST_TURN_R = 3'd2;
    localparam logic [2:0] ST_MOVE   = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;
    localparam logic [2:0] ST_UTURN  = 3'd5;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [2:0] mot;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       front_detector, left_detector, right_detector;
    logic       go_straight_command, turn_left_command, turn_right_command;
    logic       turn_back_command;
    logic       move_forward_signal, turn_left_signal, turn_right_signal;
    logic [2:0] state;
    logic       cmd_error;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb_q[$];

    semi_auto_drive_ctrl #(
        .TURN_CYCLES   (TURN_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .UTURN_CYCLES  (UTURN_CYCLES),
        .CNT_W         (8)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .front_detector      (front_detector),
        .left_detector       (left_detector),
        .right_detector      (right_detector),
        .go_straight_command (go_straight_command),
        .turn_left_command   (turn_left_command),
        .turn_right_command  (turn_right_command),
`ifdef SEMI_AUTO_DRIVE_UTURN_EN
        .turn_back_command   (turn_back_command),
`endif
        .move_forward_signal (move_forward_signal),
        .turn_left_signal    (turn_left_signal),
        .turn_right_signal   (turn_right_signal),
        .state               (state),
        .cmd_error           (cmd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] motion();
        return {move_forward_signal, turn_left_signal, turn_right_signal};
    endfunction

    task automatic drive(input logic [3:0] cmd, input logic [2:0] det);
        go_straight_command = cmd[0];
        turn_left_command   = cmd[1];
        turn_right_command  = cmd[2];
        turn_back_command   = cmd[3];
        {front_detector, left_detector, right_detector} = det;
    endtask

    // Drive one cycle of stimulus, queue what the DUT must show after the
    // next rising edge, then pop and compare once that edge has passed.
    task automatic step(input string tag, input logic [3:0] cmd, input logic [2:0] det,
                        input logic [2:0] est, input logic [2:0] emot, input logic eerr);
        exp_t e;
        exp_t got;
        drive(cmd, det);
        e.tag = tag; e.st = est; e.mot = emot; e.err = eerr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk({got.tag, ".state"}, 32'(state), 32'(got.st));
        chk({got.tag, ".motion"}, 32'(motion()), 32'(got.mot));
        chk({got.tag, ".cmd_error"}, 32'(cmd_error), 32'(got.err));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(C_NONE, 3'b000);
        #12;
        chk("reset.state", 32'(state), 32'(ST_WAIT));
        chk("reset.motion", 32'(motion()), 32'(M_NONE));
        chk("reset.cmd_error", 32'(cmd_error), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Left turn held for one cycle: 4 cycles TURN_L, 3 SETTLE, then MOVE.
        step("left_cmd", C_L, 3'b011, ST_TURN_L, M_LEFT, 1'b0);
        for (int i = 1; i < int'(TURN_CYCLES); i++)
            step("turn_l", C_NONE, 3'b011, ST_TURN_L, M_LEFT, 1'b0);
        // Detectors other than corridor must be ignored while settling.
        for (int i = 0; i < int'(SETTLE_CYCLES); i++)
            step("settle_l", C_NONE, 3'b100, ST_SETTLE, M_FWD, 1'b0);
        step("move_entry", C_NONE, 3'b011, ST_MOVE, M_FWD, 1'b0);
        for (int i = 0; i < 10; i++)
            step("corridor", C_NONE, 3'b011, ST_MOVE, M_FWD, 1'b0);
        step("right_open", C_NONE, 3'b001, ST_WAIT, M_NONE, 1'b0);

        // Straight command held through SETTLE is ignored there; conflicting
        // commands in MOVE do not raise an error.
        for (int i = 0; i < int'(SETTLE_CYCLES); i++)
            step("straight", C_S, 3'b011, ST_SETTLE, M_FWD, 1'b0);
        step("move2", C_NONE, 3'b011, ST_MOVE, M_FWD, 1'b0);
        step("multi_in_move", C_S | C_R, 3'b011, ST_MOVE, M_FWD, 1'b0);
        step("dead_end", C_NONE, 3'b111, ST_WAIT, M_NONE, 1'b0);

        // Conflicting commands in WAIT: a single error pulse over 5 cycles.
        step("conflict0", C_S | C_R, 3'b000, ST_WAIT, M_NONE, 1'b1);
        for (int i = 1; i < 5; i++)
            step("conflict_hold", C_S | C_R, 3'b000, ST_WAIT, M_NONE, 1'b0);
        step("release", C_NONE, 3'b000, ST_WAIT, M_NONE, 1'b0);
        step("right_cmd", C_R, 3'b000, ST_TURN_R, M_RGT, 1'b0);
        step("turn_r2", C_NONE, 3'b000, ST_TURN_R, M_RGT, 1'b0);

        // Asynchronous reset in the middle of the right turn.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.motion", 32'(motion()), 32'(M_NONE));
        chk("async_rst.state", 32'(state), 32'(ST_WAIT));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("post_rst.state", 32'(state), 32'(ST_WAIT));

        // First edge after reset with a one-hot command is accepted.
        step("first_cmd", C_L, 3'b000, ST_TURN_L, M_LEFT, 1'b0);
        for (int i = 1; i < int'(TURN_CYCLES); i++)
            step("turn_l2", C_NONE, 3'b000, ST_TURN_L, M_LEFT, 1'b0);
        for (int i = 0; i < int'(SETTLE_CYCLES); i++)
            step("settle2", C_NONE, 3'b000, ST_SETTLE, M_FWD, 1'b0);
        step("move3", C_NONE, 3'b000, ST_MOVE, M_FWD, 1'b0);
        step("open_space", C_NONE, 3'b000, ST_WAIT, M_NONE, 1'b0);

        // Error re-arms after the vector returned to zero.
        step("conflict2", C_S | C_L, 3'b000, ST_WAIT, M_NONE, 1'b1);
        step("release2", C_NONE, 3'b000, ST_WAIT, M_NONE, 1'b0);

`ifdef SEMI_AUTO_DRIVE_UTURN_EN
        step("back_cmd", C_B, 3'b011, ST_UTURN, M_LEFT, 1'b0);
        for (int i = 1; i < int'(UTURN_CYCLES); i++)
            step("uturn", C_NONE, 3'b011, ST_UTURN, M_LEFT, 1'b0);
        for (int i = 0; i < int'(SETTLE_CYCLES); i++)
            step("settle_u", C_NONE, 3'b011, ST_SETTLE, M_FWD, 1'b0);
        step("move_u", C_NONE, 3'b011, ST_MOVE, M_FWD, 1'b0);
        step("exit_u", C_NONE, 3'b001, ST_WAIT, M_NONE, 1'b0);
`endif

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/semi_auto_drive_ctrl.md
SEMI_AUTO_DRIVE_CTRL -- requirements
Module: semi_auto_drive_ctrl

Interface
REQ-001 Parameter TURN_CYCLES, default 1000000, number of cycles a left or right turn is held; SHALL be >= 1.
REQ-002 Parameter SETTLE_CYCLES, default 500000, forward cycles after a turn or straight command with detectors ignored; SHALL be >= 1.
REQ-003 Parameter UTURN_CYCLES, default 2000000, number of cycles a U-turn is held; SHALL be >= 1.
REQ-004 Parameter CNT_W, default 32, counter width; SHALL hold max(TURN_CYCLES, SETTLE_CYCLES, UTURN_CYCLES).
REQ-005 clk  input  1  system clock, 100 MHz, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 front_detector, left_detector, right_detector  input  1 each  high = wall or obstacle present.
REQ-008 go_straight_command, turn_left_command, turn_right_command  input  1 each  level commands from the operator.
REQ-009 turn_back_command  input  1  U-turn request; present only when UTURN_EN is defined.
REQ-010 move_forward_signal, turn_left_signal, turn_right_signal  output  1 each  motion drive, at most one high at any time.
REQ-011 state  output  3  current state encoding.
REQ-012 cmd_error  output  1  one-cycle pulse on a rejected command.

Function
REQ-013 States SHALL be WAIT=0, TURN_L=1, TURN_R=2, MOVE=3, SETTLE=4, UTURN=5; codes 6 and 7 SHALL return to WAIT on the next edge.
REQ-014 All state and counter updates SHALL occur on the rising clk edge only; no level-sensitive state assignment.
REQ-015 Motion outputs SHALL be a Moore decode of state: WAIT 000, TURN_L 010, TURN_R 001, SETTLE and MOVE 100, UTURN 010 (as {forward, left, right}).
REQ-016 In WAIT, the command vector SHALL be sampled each cycle: exactly one command high -> straight to SETTLE, left to TURN_L, right to TURN_R, back to UTURN, effective the next edge.
REQ-017 In WAIT, two or more commands high SHALL hold WAIT and pulse cmd_error for one cycle; cmd_error SHALL re-pulse only after the vector has returned to zero.
REQ-018 Commands outside WAIT SHALL be ignored and SHALL NOT raise cmd_error.
REQ-019 A single counter SHALL clear on every state entry and increment each cycle while in TURN_L, TURN_R, UTURN or SETTLE.
REQ-020 TURN_L and TURN_R SHALL last exactly TURN_CYCLES cycles, then go to SETTLE.
REQ-021 UTURN SHALL last exactly UTURN_CYCLES cycles, then go to SETTLE.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles, ignoring detectors, then go to MOVE.
REQ-023 MOVE SHALL remain while {front, left, right} == 3'b011 (corridor) and go to WAIT on any other value, including 3'b111 (dead end).
REQ-024 The counter SHALL be held at zero in WAIT and MOVE and SHALL never wrap.

Reset
REQ-025 rst_n low SHALL force, asynchronously, state=WAIT, counter=0, cmd_error=0 and all motion outputs 0, including mid-turn or mid-settle.
REQ-026 After rst_n deasserts, the first command SHALL be accepted on the first rising edge with a valid one-hot command.

Configuration
REQ-027 Macro SEMI_AUTO_DRIVE_UTURN_EN: when defined, turn_back_command and the UTURN state exist as specified.
REQ-028 When SEMI_AUTO_DRIVE_UTURN_EN is undefined, the port and UTURN state SHALL be absent, the command vector SHALL be 3 bits, and state code 5 SHALL behave as an illegal code.

Verification (TURN_CYCLES=4, SETTLE_CYCLES=3, UTURN_CYCLES=8)
REQ-029 Reset, then turn_left_command=1 for one cycle -> TURN_L with left=1 for 4 cycles, SETTLE with forward=1 for 3 cycles, then MOVE.
REQ-030 In MOVE, detectors 011 for 10 cycles, then 001 -> forward stays high through the 011 cycles, WAIT and all motion outputs 0 one edge after 001.
REQ-031 In MOVE, detectors 111 -> WAIT on the next edge.
REQ-032 In WAIT, straight and right high together for 5 cycles -> state stays WAIT, cmd_error pulses exactly once; release, then right alone -> TURN_R.
REQ-033 rst_n low at cycle 2 of TURN_R -> outputs 0 immediately without a clock; state WAIT after release.
REQ-034 With SEMI_AUTO_DRIVE_UTURN_EN, turn_back_command -> UTURN with left=1 for 8 cycles, then SETTLE for 3 cycles, then MOVE; without the macro, the build has no turn_back_command port.
